// File: rtl/booth_mult_unit.sv
// booth_mult_unit: multi-cycle signed multiplier (radix-2 Booth).
// It retires one Booth iteration per clock. The full 2*WIDTH-bit product is
// presented on hi/lo with a one-cycle done pulse, WIDTH cycles after start
// is accepted.
module booth_mult_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_n_s;
    logic             accept_s;
    logic             last_iter_s;

    // Booth datapath: the accumulator carries one extra sign bit so that the
    // most negative multiplicand can be subtracted without overflow.
    logic [WIDTH:0]   acc_r;
    logic [WIDTH:0]   m_r;
    logic [WIDTH-1:0] q_r;
    logic             q1_r;
    logic [CW-1:0]    count_r;
    logic [WIDTH-1:0] hi_r;
    logic [WIDTH-1:0] lo_r;
    logic             busy_r;
    logic             done_r;

    logic [WIDTH:0]   sum_s;
    logic [WIDTH:0]   acc_sh_s;
    logic [WIDTH-1:0] q_sh_s;
    logic             q1_sh_s;

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_n_s;
        end
    end

    // Next-state logic and start acceptance (start counts only in IDLE or DONE).
    always_comb begin
        state_n_s   = state_r;
        accept_s    = 1'b0;
        last_iter_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_n_s = ST_RUN;
                    accept_s  = 1'b1;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (count_r == CNT_ONE) begin
                    state_n_s   = ST_DONE;
                    last_iter_s = 1'b1;
                end else begin
                    state_n_s = ST_RUN;
                end
            end
            ST_DONE: begin
                if (start) begin
                    state_n_s = ST_RUN;
                    accept_s  = 1'b1;
                end else begin
                    state_n_s = ST_IDLE;
                end
            end
            default: begin
                state_n_s = ST_IDLE;
            end
        endcase
    end

    // One Booth step: conditional add/subtract of m, then arithmetic shift of {acc,Q,q_1}.
    always_comb begin
        sum_s = acc_r;
        case ({q_r[0], q1_r})
            2'b01:   sum_s = acc_r + m_r;
            2'b10:   sum_s = acc_r - m_r;
            default: sum_s = acc_r;
        endcase
        acc_sh_s = {sum_s[WIDTH], sum_s[WIDTH:1]};
        q_sh_s   = {sum_s[0], q_r[WIDTH-1:1]};
        q1_sh_s  = q_r[0];
    end

    // Operand load on accepted start, iteration during RUN, otherwise hold.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_r   <= {(WIDTH+1){1'b0}};
            m_r     <= {(WIDTH+1){1'b0}};
            q_r     <= {WIDTH{1'b0}};
            q1_r    <= 1'b0;
            count_r <= {CW{1'b0}};
        end else if (accept_s) begin
            acc_r   <= {(WIDTH+1){1'b0}};
            m_r     <= {a[WIDTH-1], a};
            q_r     <= b;
            q1_r    <= 1'b0;
            count_r <= CNT_INIT;
        end else if (state_r == ST_RUN) begin
            acc_r   <= acc_sh_s;
            q_r     <= q_sh_s;
            q1_r    <= q1_sh_s;
            count_r <= count_r - CNT_ONE;
        end else begin
            acc_r   <= acc_r;
            m_r     <= m_r;
            q_r     <= q_r;
            q1_r    <= q1_r;
            count_r <= count_r;
        end
    end

    // Result registers: capture the shifted product on the final iteration only.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_r <= {WIDTH{1'b0}};
            lo_r <= {WIDTH{1'b0}};
        end else if (last_iter_s) begin
            hi_r <= acc_sh_s[WIDTH-1:0];
            lo_r <= q_sh_s;
        end else begin
            hi_r <= hi_r;
            lo_r <= lo_r;
        end
    end

    // Status flags registered from the next state so they track state exactly.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            busy_r <= (state_n_s == ST_RUN);
            done_r <= (state_n_s == ST_DONE);
        end
    end

    assign busy = busy_r;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: tb/tb_booth_mult_unit.sv
// Scoreboard bench for booth_mult_unit: the driver pushes the expected
// product and its completion cycle. The monitor pops and compares on every done.
module tb_booth_mult_unit;

    logic        clk;
    logic        reset;
    logic [31:0] a;
    logic [31:0] b;
    logic        start;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    typedef struct {
        logic [63:0] prod;
        int          cyc;
    } exp_t;

    exp_t        exp_q[$];
    int          errors = 0;
    int          checks = 0;
    int          cyc    = 0;
    logic [63:0] held   = 64'd0;

    booth_mult_unit #(.WIDTH(32)) dut (
        .clk   (clk),
        .reset (reset),
        .a     (a),
        .b     (b),
        .start (start),
        .busy  (busy),
        .done  (done),
        .hi    (hi),
        .lo    (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [63:0] ref_mul(input logic [31:0] x, input logic [31:0] y);
        longint sx;
        longint sy;
        sx = longint'($signed(x));
        sy = longint'($signed(y));
        return 64'(sx * sy);
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%016h expected 0x%016h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    // Monitor: compare each done against the scoreboard, and check hold/exclusivity.
    always @(negedge clk) begin
        if (reset) begin
            exp_q.delete();
            held = 64'd0;
        end else begin
            if (done) begin
                chk("busy_done_exclusive", {63'd0, busy}, 64'd0);
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 64'd1, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("product", {hi, lo}, e.prod);
                    chk("done_cycle", 64'(cyc), 64'(e.cyc));
                end
                held = {hi, lo};
            end else if (busy) begin
                chk("hold_during_run", {hi, lo}, held);
            end
        end
    end

    // Drive start for one cycle; caller is positioned just after a negedge.
    task automatic drive_start(input logic [31:0] x, input logic [31:0] y, input bit expect_it);
        exp_t e;
        a     = x;
        b     = y;
        start = 1'b1;
        if (expect_it) begin
            e.prod = ref_mul(x, y);
            e.cyc  = cyc + 1 + 32;
            exp_q.push_back(e);
        end
        @(negedge clk);
        start = 1'b0;
        a     = $urandom;
        b     = $urandom;
    endtask

    task automatic wait_done(input string name);
        int n;
        n = 0;
        while (!done && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!done) chk({name, "_timeout"}, 64'd1, 64'd0);
    endtask

    task automatic drain(input string name);
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_drain"}, 64'(exp_q.size()), 64'd0);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] corners [6];
        corners[0] = 32'h0000_0000;
        corners[1] = 32'hFFFF_FFFF;
        corners[2] = 32'h8000_0000;
        corners[3] = 32'h7FFF_FFFF;
        corners[4] = 32'h0000_0001;
        corners[5] = 32'h8000_0001;

        reset = 1'b1;
        start = 1'b0;
        a     = 32'd0;
        b     = 32'd0;
        repeat (2) @(negedge clk);
        chk("reset_state", {busy, done, 30'd0, hi, lo} == 64'd0 ? 64'd0 : 64'd1, 64'd0);
        chk("reset_hi", {32'd0, hi}, 64'd0);
        reset = 1'b0;
        @(negedge clk);

        // Directed cases.
        drive_start(32'd3, 32'd5, 1'b1);
        drain("a3b5");
        chk("a3b5_lo", {32'd0, lo}, 64'd15);
        chk("done_one_cycle", {63'd0, done}, 64'd0);

        drive_start(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        drain("m1m1");
        drive_start(32'h8000_0000, 32'h8000_0000, 1'b1);
        drain("minmin");
        chk("minmin_hi", {32'd0, hi}, 64'h0000_0000_4000_0000);

        // Back-to-back: restart while done is high.
        drive_start(32'h7FFF_FFFF, 32'hFFFF_FFFF, 1'b1);
        wait_done("b2b");
        drive_start(32'd2, 32'hFFFF_FFFD, 1'b1);
        drain("b2b");
        chk("b2b_final", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFA);

        // Start during RUN is ignored.
        drive_start(32'h1234_5678, 32'h9ABC_DEF0, 1'b1);
        repeat (9) @(negedge clk);
        drive_start(32'h0000_0007, 32'h0000_0009, 1'b0);
        drain("ignored_start");

        // Reset mid-RUN aborts with no done.
        drive_start(32'h0BAD_F00D, 32'hDEAD_BEEF, 1'b1);
        repeat (15) @(negedge clk);
        #2 reset = 1'b1;
        #1;
        chk("abort_busy", {63'd0, busy}, 64'd0);
        chk("abort_done", {63'd0, done}, 64'd0);
        chk("abort_hilo", {hi, lo}, 64'd0);
        @(negedge clk);
        #2 reset = 1'b0;
        @(negedge clk);
        repeat (40) @(negedge clk);
        chk("no_done_after_abort", 64'(exp_q.size()), 64'd0);
        drive_start(32'hFFFF_FFF9, 32'h0000_0006, 1'b1);
        drain("after_reset");

        // Randomized traffic with corners, random gaps and occasional restarts on done.
        for (int i = 0; i < 24; i++) begin
            logic [31:0] x;
            logic [31:0] y;
            x = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            y = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 5)] : $urandom;
            drive_start(x, y, 1'b1);
            if ($urandom_range(0, 1) == 1) begin
                wait_done("rand");
            end else begin
                drain("rand");
                repeat ($urandom_range(0, 3)) @(negedge clk);
            end
        end
        drain("final");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
